// File: rtl/axi_arb_pkg.sv
// Shared types and payload layout constants for the two-requester AXI write arbiter.
package axi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } state_t;

  // AW payload is {addr, len[7:0], size[2:0], burst[1:0]}; everything below addr is the header
  localparam int unsigned AW_HDR_W   = 13;
  localparam int unsigned AW_LEN_LSB = 5;
  localparam int unsigned LEN_W      = 8;

  // W payload is {data, strb, last}
  localparam int unsigned W_LAST_BIT = 0;
  localparam int unsigned W_STRB_LSB = 1;

  localparam logic [1:0] OKAY = 2'b00;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker; ptr names the requester preferred on a tie.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);

  // Single requester wins outright; a tie goes to the requester named by ptr
  always_comb begin
    gnt = req;
    if (&req) gnt = ptr ? 2'b10 : 2'b01;
  end

endmodule

// File: rtl/axi_wr_arbiter.sv
// Round-robin arbiter granting one requester a whole AXI write (AW, W burst, B) at a time.
module axi_wr_arbiter
  import axi_arb_pkg::*;
#(
  parameter int unsigned AW  = 32,
  parameter int unsigned DW  = 64,
  parameter int unsigned SW  = DW / 8,
  parameter int unsigned AWP = AW + AW_HDR_W,
  parameter int unsigned WP  = DW + SW + 1
) (
  input  logic             axi_aclk,
  input  logic             axi_aresetn,
  input  logic [2*AWP-1:0] m_aw,
  input  logic [1:0]       m_awvalid,
  output logic [1:0]       m_awready,
  input  logic [2*WP-1:0]  m_w,
  input  logic [1:0]       m_wvalid,
  output logic [1:0]       m_wready,
  output logic [3:0]       m_bresp,
  output logic [1:0]       m_bvalid,
  input  logic [1:0]       m_bready,
  output logic [AWP-1:0]   s_aw,
  output logic             s_awvalid,
  input  logic             s_awready,
  output logic [WP-1:0]    s_w,
  output logic             s_wvalid,
  input  logic             s_wready,
  input  logic [1:0]       s_bresp,
  input  logic             s_bvalid,
  output logic             s_bready,
  output logic [1:0]       grant,
  output logic             wlast_err
);

  state_t             state_q, state_d;
  logic               g_q, g_d;
  logic               ptr_q, ptr_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [LEN_W-1:0]   len_q, len_d;

  logic [1:0]         pick;
  logic [AWP-1:0]     aw_sel;
  logic [WP-1:0]      w_sel;
  logic               last_regen;
  logic               aw_hs;
  logic               w_hs;
  logic               b_hs;

  rr_arb2 u_rr_arb2 (
    .req (m_awvalid),
    .ptr (ptr_q),
    .gnt (pick)
  );

  // Owner payload selection and handshake qualifiers
  always_comb begin
    aw_sel     = g_q ? m_aw[2*AWP-1:AWP] : m_aw[AWP-1:0];
    w_sel      = g_q ? m_w[2*WP-1:WP]    : m_w[WP-1:0];
    last_regen = (cnt_q == len_q);
    aw_hs      = (state_q == ADDR) && m_awvalid[g_q] && s_awready;
    w_hs       = (state_q == DATA) && m_wvalid[g_q] && s_wready;
    b_hs       = (state_q == RESP) && s_bvalid && m_bready[g_q];
  end

  // State, owner, pointer, beat counter and burst length registers
  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      state_q <= IDLE;
      g_q     <= 1'b0;
      ptr_q   <= 1'b0;
      cnt_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
    end
  end

  // Next-state logic and zero-latency channel muxing towards the current owner
  always_comb begin
    state_d   = state_q;
    g_d       = g_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    m_awready = 2'b00;
    m_wready  = 2'b00;
    m_bresp   = {OKAY, OKAY};
    m_bvalid  = 2'b00;
    s_aw      = '0;
    s_awvalid = 1'b0;
    s_w       = '0;
    s_wvalid  = 1'b0;
    s_bready  = 1'b0;
    wlast_err = 1'b0;

    case (state_q)
      IDLE: begin
        if (|m_awvalid) begin
          g_d     = pick[1];
          state_d = ADDR;
        end
      end

      ADDR: begin
        s_aw           = aw_sel;
        s_awvalid      = m_awvalid[g_q];
        m_awready[g_q] = s_awready;
        if (aw_hs) begin
          len_d   = aw_sel[AW_LEN_LSB +: LEN_W];
          cnt_d   = '0;
          state_d = DATA;
        end
      end

      DATA: begin
        // Downstream last comes from the beat counter, not from the requester
        s_w           = {w_sel[WP-1:W_STRB_LSB], last_regen};
        s_wvalid      = m_wvalid[g_q];
        m_wready[g_q] = s_wready;
        if (w_hs) begin
          cnt_d     = LEN_W'(cnt_q + LEN_W'(1));
          wlast_err = (w_sel[W_LAST_BIT] != last_regen);
          if (last_regen) state_d = RESP;
        end
      end

      RESP: begin
        m_bvalid[g_q] = s_bvalid;
        if (g_q) m_bresp[3:2] = s_bresp;
        else     m_bresp[1:0] = s_bresp;
        s_bready = m_bready[g_q];
        if (b_hs) begin
          ptr_d   = ~g_q;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // One-hot owner indication while a transaction is in progress
  always_comb begin
    grant = 2'b00;
    if (state_q != IDLE) grant = g_q ? 2'b10 : 2'b01;
  end

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Directed self-checking bench for axi_wr_arbiter.
module tb_axi_wr_arbiter;
  import axi_arb_pkg::*;

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 64;
  localparam int unsigned SW  = 8;
  localparam int unsigned AWP = AW + 13;
  localparam int unsigned WP  = DW + SW + 1;

  logic             axi_aclk;
  logic             axi_aresetn;
  logic [2*AWP-1:0] m_aw;
  logic [1:0]       m_awvalid;
  logic [1:0]       m_awready;
  logic [2*WP-1:0]  m_w;
  logic [1:0]       m_wvalid;
  logic [1:0]       m_wready;
  logic [3:0]       m_bresp;
  logic [1:0]       m_bvalid;
  logic [1:0]       m_bready;
  logic [AWP-1:0]   s_aw;
  logic             s_awvalid;
  logic             s_awready;
  logic [WP-1:0]    s_w;
  logic             s_wvalid;
  logic             s_wready;
  logic [1:0]       s_bresp;
  logic             s_bvalid;
  logic             s_bready;
  logic [1:0]       grant;
  logic             wlast_err;

  int n_cmp = 0;
  int n_err = 0;

  axi_wr_arbiter #(
    .AW (AW), .DW (DW), .SW (SW), .AWP (AWP), .WP (WP)
  ) dut (
    .axi_aclk    (axi_aclk),
    .axi_aresetn (axi_aresetn),
    .m_aw        (m_aw),
    .m_awvalid   (m_awvalid),
    .m_awready   (m_awready),
    .m_w         (m_w),
    .m_wvalid    (m_wvalid),
    .m_wready    (m_wready),
    .m_bresp     (m_bresp),
    .m_bvalid    (m_bvalid),
    .m_bready    (m_bready),
    .s_aw        (s_aw),
    .s_awvalid   (s_awvalid),
    .s_awready   (s_awready),
    .s_w         (s_w),
    .s_wvalid    (s_wvalid),
    .s_wready    (s_wready),
    .s_bresp     (s_bresp),
    .s_bvalid    (s_bvalid),
    .s_bready    (s_bready),
    .grant       (grant),
    .wlast_err   (wlast_err)
  );

  initial begin
    axi_aclk = 1'b0;
    forever #5 axi_aclk = ~axi_aclk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end expected end before 200000");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 2 ns after the rising edge; outputs are checked 1 ns later
  task automatic step();
    @(posedge axi_aclk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [AWP-1:0] mk_aw(input logic [31:0] addr, input logic [7:0] len);
    return {addr, len, 3'd3, 2'b01};
  endfunction

  function automatic logic [WP-1:0] mk_w(input logic [63:0] d, input logic [7:0] s, input logic l);
    return {d, s, l};
  endfunction

  function automatic logic [1:0] onehot(input int id);
    return (id != 0) ? 2'b10 : 2'b01;
  endfunction

  task automatic check_quiet(input string tag);
    check_eq({tag, "_grant"},    grant,     2'b00);
    check_eq({tag, "_awvalid"},  s_awvalid, 1'b0);
    check_eq({tag, "_awready"},  m_awready, 2'b00);
    check_eq({tag, "_wvalid"},   s_wvalid,  1'b0);
    check_eq({tag, "_wready"},   m_wready,  2'b00);
    check_eq({tag, "_bvalid"},   m_bvalid,  2'b00);
    check_eq({tag, "_bresp"},    m_bresp,   4'b0000);
    check_eq({tag, "_bready"},   s_bready,  1'b0);
    check_eq({tag, "_wlasterr"}, wlast_err, 1'b0);
  endtask

  // One full transaction for requester id, starting in an IDLE cycle.
  // bp toggles s_wready, bad_beat marks the beat with a bogus requester wlast,
  // early raises wvalid before the address, stall holds s_awready low one cycle.
  task automatic txn(input int id, input int len, input bit bp, input int bad_beat,
                     input bit early, input bit stall);
    logic [1:0]     oh;
    logic [AWP-1:0] aw;
    logic [WP-1:0]  w;
    logic [1:0]     resp;
    logic [3:0]     exp_bresp;
    int             b;
    bit             wr;

    oh = onehot(id);
    aw = mk_aw(32'h1000_0000 + 32'(id * 256) + 32'(len), 8'(len));
    m_aw[id*AWP +: AWP] = aw;
    m_awvalid[id] = 1'b1;
    if (early) begin
      m_w[id*WP +: WP] = mk_w(64'hEEEE_0000_0000_0001, 8'hFF, 1'b0);
      m_wvalid[id] = 1'b1;
    end
    s_awready = !stall;
    settle();
    check_eq("idle_grant",   grant,     2'b00);
    check_eq("idle_awready", m_awready, 2'b00);
    check_eq("idle_wready",  m_wready,  2'b00);
    step();

    if (stall) begin
      settle();
      check_eq("stall_grant",   grant,     oh);
      check_eq("stall_awvalid", s_awvalid, 1'b1);
      check_eq("stall_awready", m_awready, 2'b00);
      check_eq("stall_wready",  m_wready,  2'b00);
      step();
      s_awready = 1'b1;
    end

    settle();
    check_eq("addr_grant",   grant,     oh);
    check_eq("addr_aw",      s_aw,      aw);
    check_eq("addr_awvalid", s_awvalid, 1'b1);
    check_eq("addr_awready", m_awready, oh);
    check_eq("addr_wready",  m_wready,  2'b00);
    check_eq("addr_wvalid",  s_wvalid,  1'b0);
    step();

    m_awvalid[id] = 1'b0;
    b  = 0;
    wr = 1'b1;
    while (b <= len) begin
      s_wready = wr;
      w = mk_w({32'hD0D0_0000, 8'(id), 8'(b), 16'h55AA}, 8'hF0 | 8'(b),
               (b == len) || (b == bad_beat));
      m_w[id*WP +: WP] = w;
      m_wvalid[id] = 1'b1;
      settle();
      check_eq("data_grant",   grant,     oh);
      check_eq("data_wvalid",  s_wvalid,  1'b1);
      check_eq("data_wready",  m_wready,  wr ? oh : 2'b00);
      check_eq("data_w",       s_w,       {w[WP-1:1], (b == len)});
      check_eq("data_wlasterr", wlast_err, wr && (b == bad_beat));
      check_eq("data_awready", m_awready, 2'b00);
      step();
      if (wr) b++;
      if (bp) wr = !wr;
    end
    m_wvalid[id] = 1'b0;
    s_wready = 1'b0;

    resp = (id != 0) ? 2'b10 : OKAY;
    exp_bresp = (id != 0) ? {resp, 2'b00} : {2'b00, resp};
    s_bresp = resp;
    s_bvalid = 1'b1;
    m_bready[id] = 1'b1;
    settle();
    check_eq("resp_grant",  grant,    oh);
    check_eq("resp_bvalid", m_bvalid, oh);
    check_eq("resp_bresp",  m_bresp,  exp_bresp);
    check_eq("resp_bready", s_bready, 1'b1);
    check_eq("resp_wvalid", s_wvalid, 1'b0);
    step();
    s_bvalid = 1'b0;
    m_bready[id] = 1'b0;
    s_bresp = 2'b00;
  endtask

  task automatic do_reset();
    axi_aresetn = 1'b0;
    m_awvalid = 2'b00;
    m_wvalid  = 2'b00;
    m_bready  = 2'b00;
    s_bvalid  = 1'b0;
    step();
    step();
    settle();
    check_quiet("rst");
    axi_aresetn = 1'b1;
    step();
  endtask

  initial begin
    axi_aresetn = 1'b0;
    m_aw      = '0;
    m_awvalid = 2'b00;
    m_w       = '0;
    m_wvalid  = 2'b00;
    m_bready  = 2'b00;
    s_awready = 1'b0;
    s_wready  = 1'b0;
    s_bresp   = 2'b00;
    s_bvalid  = 1'b0;

    do_reset();

    // Single request, len=3, leaves ptr at 1
    txn(0, 3, 1'b0, -1, 1'b0, 1'b0);

    // Tie with ptr=1 goes to requester 1, then requester 0 after an IDLE cycle
    m_awvalid[0] = 1'b1;
    txn(1, 0, 1'b0, -1, 1'b0, 1'b0);
    txn(0, 0, 1'b0, -1, 1'b0, 1'b0);

    // Tie straight after reset goes to requester 0: grant 01, 00, 10
    do_reset();
    m_awvalid[1] = 1'b1;
    txn(0, 0, 1'b0, -1, 1'b0, 1'b0);
    txn(1, 0, 1'b0, -1, 1'b0, 1'b0);

    // Backpressure on a len=2 burst while requester 1 keeps its valids high
    m_awvalid[1] = 1'b1;
    m_w[WP +: WP] = mk_w(64'hBBBB_BBBB_BBBB_BBBB, 8'hAA, 1'b1);
    m_wvalid[1] = 1'b1;
    txn(0, 2, 1'b1, -1, 1'b0, 1'b0);
    m_wvalid[1] = 1'b0;
    txn(1, 0, 1'b0, -1, 1'b0, 1'b0);

    // Requester wlast on beat 2 of a 4-beat burst
    txn(0, 3, 1'b0, 1, 1'b0, 1'b0);

    // Early W with an address stall
    txn(1, 1, 1'b0, -1, 1'b1, 1'b1);

    // Leave ptr at 1, then reset in the middle of a burst
    txn(0, 0, 1'b0, -1, 1'b0, 1'b0);
    m_aw[AWP-1:0] = mk_aw(32'h2000_0000, 8'd3);
    m_awvalid = 2'b01;
    s_awready = 1'b1;
    s_wready  = 1'b1;
    step();
    step();
    m_awvalid = 2'b00;
    m_w[WP-1:0] = mk_w(64'h1111_2222_3333_4444, 8'hFF, 1'b0);
    m_wvalid = 2'b01;
    settle();
    check_eq("mid_wvalid_pre", s_wvalid, 1'b1);
    step();
    axi_aresetn = 1'b0;
    s_bvalid = 1'b1;
    m_bready = 2'b11;
    step();
    settle();
    check_quiet("mid_rst");
    axi_aresetn = 1'b1;
    m_wvalid = 2'b00;
    m_bready = 2'b00;
    s_bvalid = 1'b0;
    step();
    // ptr must be back at 0: a tie goes to requester 0
    m_awvalid[1] = 1'b1;
    txn(0, 0, 1'b0, -1, 1'b0, 1'b0);
    txn(1, 0, 1'b0, -1, 1'b0, 1'b0);
    settle();
    check_quiet("end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axi_wr_arbiter.md
Name: axi_wr_arbiter

Overview:
- Two-requester arbiter for the single AXI write path (AW, W and B channels) feeding the write-channel FSMs.
- Grants one requester a complete write transaction: address handshake, full data burst, then write response. Only after the response does it re-arbitrate.
- Uses round-robin priority. Downstream WLAST is regenerated from a beat counter loaded from AWLEN, and a requester whose WLAST disagrees with the counter is flagged.

Parameters:
- AW, 32, address width
- DW, 64, write data width
- SW, 8, strobe width (DW/8)
- AWP, AW+13, AW payload width {addr, len[7:0], size[2:0], burst[1:0]}
- WP, DW+SW+1, W payload width {data, strb, last}

Ports:
- axi_aclk  in  1  clock
- axi_aresetn  in  1  synchronous active-low reset
- m_aw  in  2*AWP  per-requester AW payload, requester i at slice [i*AWP +: AWP]
- m_awvalid  in  2  per-requester AW valid
- m_awready  out  2  per-requester AW ready
- m_w  in  2*WP  per-requester W payload
- m_wvalid  in  2  per-requester W valid
- m_wready  out  2  per-requester W ready
- m_bresp  out  4  per-requester B response, 2 bits each
- m_bvalid  out  2  per-requester B valid
- m_bready  in  2  per-requester B ready
- s_aw  out  AWP  downstream AW payload
- s_awvalid  out  1  downstream AW valid
- s_awready  in  1  downstream AW ready
- s_w  out  WP  downstream W payload (last bit regenerated)
- s_wvalid  out  1  downstream W valid
- s_wready  in  1  downstream W ready
- s_bresp  in  2  downstream B response
- s_bvalid  in  1  downstream B valid
- s_bready  out  1  downstream B ready
- grant  out  2  one-hot current owner; 0 when idle
- wlast_err  out  1  one-cycle pulse on a requester WLAST mismatch

Behaviour:
- Clock axi_aclk; reset axi_aresetn is synchronous and active-low.
- Registered state: FSM state, owner id g, round-robin pointer ptr, beat counter cnt[7:0], latched length len[7:0].
- All channel outputs are combinational muxes of the registered owner and state. Handshakes pass through with zero added latency.
- Reset (including mid-transfer):
  - State goes to IDLE, ptr=0, cnt=0, len=0, grant=0, wlast_err=0.
  - Every valid and ready output is 0 from the first cycle after the reset edge.
  - An in-flight burst is abandoned; no completion is emitted.
- IDLE:
  - All m_*ready, m_bvalid, s_awvalid, s_wvalid and s_bready are 0.
  - If any m_awvalid is high, the owner is chosen as follows. If both are high, owner is ptr. Otherwise owner is the single asserting requester.
  - Owner is registered into g; the FSM goes to ADDR next cycle. This gives 1 cycle of arbitration latency.
- ADDR:
  - s_aw=m_aw[g], s_awvalid=m_awvalid[g], m_awready[g]=s_awready.
  - On s_awvalid&s_awready: latch len=awlen, cnt=0, go to DATA.
- DATA:
  - s_w payload = owner data and strb; s_w last bit = (cnt==len).
  - s_wvalid=m_wvalid[g], m_wready[g]=s_wready.
  - On each beat handshake: cnt++.
  - If the owner WLAST != (cnt==len), pulse wlast_err for 1 cycle. Forwarding continues unchanged.
  - On the beat handshake with cnt==len: go to RESP.
  - len=0 means a single beat.
- RESP:
  - m_bvalid[g]=s_bvalid, m_bresp[g]=s_bresp, s_bready=m_bready[g].
  - On handshake: go to IDLE and set ptr=~g (the other requester is preferred next).
- Non-owner requester:
  - Its ready and bvalid outputs are held 0 at all times.
  - Its m_bresp slice is 0.
  - Its valids are ignored.
- W beats presented before the AW is accepted are held off (wready=0) until DATA.
- grant = one-hot of g in ADDR, DATA and RESP; 0 in IDLE.
- A requester dropping awvalid in ADDR before the handshake causes no state change (protocol violation, not recovered).

Decomposition:
- Shared package axi_arb_pkg holds:
  - state enum {IDLE, ADDR, DATA, RESP}
  - payload field offset constants for the AW and W payloads
  - OKAY=2'b00
- One sub-module, rr_arb2: 2-way round-robin picker with inputs req[1:0] and ptr, output gnt[1:0]. It is combinational; ptr stays in the parent.

Test Plan:
- Single request: m_awvalid=01, len=3, s_*ready=1 → grant=01 one cycle later; 4 W beats forwarded; s_w last high on beat 4 only; B forwarded; back to IDLE; ptr=1.
- Simultaneous requests after reset: both awvalid, len=0 → requester 0 served first, then requester 1 after an IDLE cycle; grant sequence 01, 00, 10.
- Backpressure: s_wready toggling 1,0,1,0 during a len=2 burst → cnt advances only on handshakes; requester 1 readies stay 0 throughout.
- WLAST mismatch: owner asserts wlast on beat 2 of len=3 → wlast_err pulses once on beat 2; s_w last asserted only on beat 4; transaction completes.
- Early W: owner asserts wvalid before awvalid → m_wready=0 until the AW handshake, then the data passes.
- Mid-burst reset: axi_aresetn=0 during DATA beat 2 → next cycle all valid/ready outputs are 0, grant=0, ptr=0.
